// File: rtl/alu_seq_param_if.sv
// Operand/result bus between a sequencing master and the sequential ALU.
// The master drives the start strobe, opcode and operand words; the ALU returns result words and status.
interface alu_seq_param_if #(
    parameter int WIDTH = 8
) ();
    logic             BEGIN;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] inbus;
    logic [WIDTH-1:0] outbus;
    logic             out_valid;
    logic             END;
    logic             busy;
    logic             err;

    modport master (
        output BEGIN, op_code, inbus,
        input  outbus, out_valid, END, busy, err
    );

    modport slave (
        input  BEGIN, op_code, inbus,
        output outbus, out_valid, END, busy, err
    );
endinterface

// File: rtl/alu_seq_param.sv
// Parametrised sequential ALU: add/sub in one cycle, shift-add multiply and restoring divide over WIDTH cycles.
// Operands arrive one word per cycle after BEGIN; results leave as a low word then a high word with END.
module alu_seq_param #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           reset,
    alu_seq_param_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_X, S_LOAD_Y, S_EXEC, S_OUT_LO, S_OUT_HI
    } state_e;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00, OP_SUB = 2'b01, OP_MUL = 2'b10, OP_DIV = 2'b11
    } op_e;

    state_e           r_state;
    op_e              r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [WIDTH-1:0] r_a;      // accumulator / remainder / high result word
    logic [WIDTH-1:0] r_q;      // multiplier / quotient / low result word
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_outbus;
    logic             r_out_valid;
    logic             r_end;
    logic             r_busy;
    logic             r_err;

    logic [WIDTH:0]   w_add;
    logic [WIDTH:0]   w_sub;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH:0]   w_div_part;
    logic [WIDTH:0]   w_div_diff;

    assign w_add      = {1'b0, r_x} + {1'b0, r_y};
    assign w_sub      = {1'b0, r_x} - {1'b0, r_y};
    assign w_mul_sum  = {1'b0, r_a} + (r_q[0] ? {1'b0, r_x} : {(WIDTH+1){1'b0}});
    assign w_div_part = {r_a, r_q[WIDTH-1]};
    assign w_div_diff = w_div_part - {1'b0, r_y};

    // NOTE: state uses non-blocking assignments only and every register, including the datapath, is
    // cleared by the synchronous reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_op        <= OP_ADD;
            r_x         <= '0;
            r_y         <= '0;
            r_a         <= '0;
            r_q         <= '0;
            r_cnt       <= '0;
            r_outbus    <= '0;
            r_out_valid <= 1'b0;
            r_end       <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_outbus    <= '0;
            r_out_valid <= 1'b0;
            r_end       <= 1'b0;
            r_busy      <= (r_state != S_IDLE) || bus.BEGIN;

            case (r_state)
                S_IDLE: begin
                    if (bus.BEGIN) begin
                        r_op    <= op_e'(bus.op_code);
                        r_err   <= 1'b0;
                        r_state <= S_LOAD_X;
                    end
                end
                S_LOAD_X: begin
                    r_x     <= bus.inbus;
                    r_state <= S_LOAD_Y;
                end
                S_LOAD_Y: begin
                    r_y     <= bus.inbus;
                    r_a     <= '0;
                    r_q     <= (r_op == OP_DIV) ? r_x : bus.inbus;
                    // Single-cycle EXEC for add/sub and for a zero divisor.
                    if (r_op == OP_ADD || r_op == OP_SUB || (r_op == OP_DIV && bus.inbus == '0))
                        r_cnt <= CW'(1);
                    else
                        r_cnt <= CW'(WIDTH);
                    r_state <= S_EXEC;
                end
                S_EXEC: begin
                    case (r_op)
                        OP_ADD: begin
                            r_q <= w_add[WIDTH-1:0];
                            r_a <= {{(WIDTH-1){1'b0}}, w_add[WIDTH]};
                        end
                        OP_SUB: begin
                            r_q <= w_sub[WIDTH-1:0];
                            r_a <= {{(WIDTH-1){1'b0}}, w_sub[WIDTH]};
                        end
                        OP_MUL: begin
                            r_a <= w_mul_sum[WIDTH:1];
                            r_q <= {w_mul_sum[0], r_q[WIDTH-1:1]};
                        end
                        default: begin
                            if (r_y == '0) begin
                                r_q   <= '1;
                                r_a   <= r_x;
                                r_err <= 1'b1;
                            end else if (!w_div_diff[WIDTH]) begin
                                r_a <= w_div_diff[WIDTH-1:0];
                                r_q <= {r_q[WIDTH-2:0], 1'b1};
                            end else begin
                                r_a <= w_div_part[WIDTH-1:0];
                                r_q <= {r_q[WIDTH-2:0], 1'b0};
                            end
                        end
                    endcase
                    r_cnt <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1))
                        r_state <= S_OUT_LO;
                end
                S_OUT_LO: begin
                    r_outbus    <= r_q;
                    r_out_valid <= 1'b1;
                    r_state     <= S_OUT_HI;
                end
                S_OUT_HI: begin
                    r_outbus    <= r_a;
                    r_out_valid <= 1'b1;
                    r_end       <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.outbus    = r_outbus;
    assign bus.out_valid = r_out_valid;
    assign bus.END       = r_end;
    assign bus.busy      = r_busy;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param at WIDTH=8 and WIDTH=16 with hand-computed results and cycle-exact timing.
module tb_alu_seq_param;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    alu_seq_param_if #(.WIDTH(8))  if8 ();
    alu_seq_param_if #(.WIDTH(16)) if16 ();

    alu_seq_param #(.WIDTH(8))  dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
    alu_seq_param #(.WIDTH(16)) dut16 (.clk(clk), .reset(reset), .bus(if16.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input bit wide, input string tag, input logic [31:0] e_out,
                             input bit e_valid, input bit e_end, input bit e_busy, input bit e_err);
        if (wide) begin
            check({tag, " outbus"},    32'(if16.outbus),    e_out);
            check({tag, " out_valid"}, 32'(if16.out_valid), 32'(e_valid));
            check({tag, " END"},       32'(if16.END),       32'(e_end));
            check({tag, " busy"},      32'(if16.busy),      32'(e_busy));
            check({tag, " err"},       32'(if16.err),       32'(e_err));
        end else begin
            check({tag, " outbus"},    32'(if8.outbus),     e_out);
            check({tag, " out_valid"}, 32'(if8.out_valid),  32'(e_valid));
            check({tag, " END"},       32'(if8.END),        32'(e_end));
            check({tag, " busy"},      32'(if8.busy),       32'(e_busy));
            check({tag, " err"},       32'(if8.err),        32'(e_err));
        end
    endtask

    task automatic drive(input bit wide, input bit b, input logic [1:0] op, input logic [31:0] d);
        if (wide) begin
            if16.BEGIN = b; if16.op_code = op; if16.inbus = d[15:0];
        end else begin
            if8.BEGIN = b; if8.op_code = op; if8.inbus = d[7:0];
        end
    endtask

    // Entered #1 after an edge. Cycle k denotes the value seen by edge k, i.e. sampled #1 after edge k-1.
    task automatic run_op(input string name, input bit wide, input logic [1:0] op,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input bit e_err, input int n, input bit hold);
        logic [31:0] e_out;
        drive(wide, 1'b1, op, 32'd0);
        @(posedge clk); #1;
        for (int k = 1; k <= 6 + n; k++) begin
            if (k == 1)      drive(wide, hold, op, x);
            else if (k == 2) drive(wide, hold, op, y);
            else             drive(wide, hold && (k < 5 + n), op, 32'd0);
            e_out = (k == 4 + n) ? lo : (k == 5 + n) ? hi : 32'd0;
            check_all(wide, $sformatf("%s c%0d", name, k), e_out,
                      (k == 4 + n) || (k == 5 + n), (k == 5 + n), (k <= 5 + n),
                      (k >= 3 + n) ? e_err : 1'b0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'd0);
        drive(1'b1, 1'b0, 2'b00, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_all(1'b0, "reset w8",  32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_all(1'b1, "reset w16", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("add 3+2",     1'b0, 2'b00, 3,   2,   5,   0,   1'b0, 1, 1'b0);
        run_op("add 200+100", 1'b0, 2'b00, 200, 100, 44,  1,   1'b0, 1, 1'b0);
        run_op("sub 5-7",     1'b0, 2'b01, 5,   7,   254, 1,   1'b0, 1, 1'b0);
        run_op("sub 9-9",     1'b0, 2'b01, 9,   9,   0,   0,   1'b0, 1, 1'b0);
        run_op("mul 7x3",     1'b0, 2'b10, 7,   3,   21,  0,   1'b0, 8, 1'b0);
        run_op("mul 255x255", 1'b0, 2'b10, 255, 255, 1,   254, 1'b0, 8, 1'b0);
        run_op("div 100/7",   1'b0, 2'b11, 100, 7,   14,  2,   1'b0, 8, 1'b0);
        run_op("div 100/0",   1'b0, 2'b11, 100, 0,   255, 100, 1'b1, 1, 1'b0);

        // Divide-by-zero flag stays up while idle and drops on the next accepted BEGIN.
        repeat (3) @(posedge clk);
        #1;
        check("err held idle", 32'(if8.err), 32'd1);
        run_op("add 10+20",   1'b0, 2'b00, 10,  20,  30,  0,   1'b0, 1, 1'b0);

        // Reset sampled at cycle 6 of a multiply discards the operation.
        drive(1'b0, 1'b1, 2'b10, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 32'd255);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 32'd255);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 2'b10, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mul busy before reset", 32'(if8.busy), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all(1'b0, "after mid-mul reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        check_all(1'b0, "idle after reset", 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        run_op("add 1+1",      1'b0, 2'b00, 1, 1, 2, 0, 1'b0, 1, 1'b0);
        run_op("add 1+1 hold", 1'b0, 2'b00, 1, 1, 2, 0, 1'b0, 1, 1'b1);

        run_op("w16 mul 300x300",   1'b1, 2'b10, 300,   300, 32'h5F90, 32'h0001, 1'b0, 16, 1'b0);
        run_op("w16 div 65535/256", 1'b1, 2'b11, 65535, 256, 255,      255,      1'b0, 16, 1'b0);
        run_op("w16 add 65535+1",   1'b1, 2'b00, 65535, 1,   0,        1,        1'b0, 1,  1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_seq_param.md
# alu_seq_param

Parametrised sequential ALU that generalises the team's 8-bit bus-oriented ALU to any operand width and adds a full divide path, a two-word result stream and an error flag. Operands arrive one word per cycle on `inbus` after a `BEGIN` strobe. An internal FSM with a shared accumulator/quotient datapath runs add, subtract, shift-add multiply or restoring divide. Results leave on `outbus` as two words, with `END` marking the last word. It sits behind the same control/register plumbing as the existing ALU and is exercised by the same style of bench.

## Interface
- `WIDTH`, default 8, operand/bus width in bits; legal range 4..32.
- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; returns FSM to IDLE and clears all registers and outputs.
- `BEGIN`  in  1  start strobe, sampled only in IDLE.
- `op_code`  in  2  sampled with `BEGIN`: 00 add, 01 sub, 10 mul (unsigned), 11 div (unsigned).
- `inbus`  in  WIDTH  operand X on the first cycle after start, operand Y on the second.
- `outbus`  out  WIDTH  result word while `out_valid`=1, else 0.
- `out_valid`  out  1  high for exactly the two result cycles.
- `END`  out  1  high only on the second (last) result cycle.
- `busy`  out  1  high from LOAD_X through OUT_HI inclusive.
- `err`  out  1  divide-by-zero flag; set at the end of EXEC, held until the next accepted `BEGIN` or reset.

## Operation
- States: IDLE → LOAD_X → LOAD_Y → EXEC → OUT_LO → OUT_HI → IDLE.
- IDLE: when `BEGIN`=1, latch `op_code`, clear `err`, go to LOAD_X. `BEGIN` is ignored in all other states.
- LOAD_X: capture `inbus` into X. LOAD_Y: capture `inbus` into Y and load the iteration counter.
- EXEC for add/sub: one cycle; WIDTH+1-bit sum or difference.
  - Low word = result[WIDTH-1:0].
  - High word = {0…0, carry} for add, {0…0, borrow} for sub. Borrow = (X < Y).
- EXEC for mul: WIDTH iterations of shift-add over a 2·WIDTH product register (A:Q, multiplicand M = X, multiplier Q = Y).
  - Low word = product[WIDTH-1:0], high word = product[2·WIDTH-1:WIDTH].
- EXEC for div: WIDTH iterations of restoring division, dividend X, divisor Y.
  - Low word = quotient, high word = remainder.
  - Y = 0: skip iterations (EXEC lasts 1 cycle), quotient = all ones, remainder = X, `err`=1.
- Counter is sized to hold WIDTH. It decrements once per EXEC cycle; EXEC exits when it reaches 0.
- OUT_LO drives the low word, OUT_HI drives the high word. No backpressure; the consumer must take both words.
- Reset at any time, including mid-EXEC: FSM returns to IDLE on the next edge and the partial result is discarded.

## Timing
- Cycle 0 = the edge that samples `BEGIN`=1 in IDLE. X is sampled at cycle 1, Y at cycle 2.
- N = 1 for add/sub and for div-by-zero; N = WIDTH for mul/div.
- EXEC occupies cycles 3..2+N. OUT_LO is cycle 3+N, OUT_HI (with `END`) is cycle 4+N, IDLE resumes at cycle 5+N.
- Latency from `BEGIN` to `END`: 6 cycles for add/sub, WIDTH+5 cycles for mul/div (13 at WIDTH=8).
- Earliest next `BEGIN` is sampled in the IDLE cycle right after `END`. Back-to-back throughput: one op per N+5 cycles.
- Reset values: `outbus`=0, `out_valid`=0, `END`=0, `busy`=0, `err`=0; all internal registers 0.
- Outputs are registered. No combinational path from any input to any output.

## Test plan
- WIDTH=8. Add 3+2, then add 200+100 → words (5, 0) with `END` at cycle 6; then (44, 1) for the carry case.
- WIDTH=8. Sub 5−7 → (254, 1); sub 9−9 → (0, 0); `busy` spans cycles 1..6.
- WIDTH=8. Mul 7×3 → (21, 0); mul 255×255 → (1, 254); `END` at cycle 13.
- WIDTH=8. Div 100÷7 → (14, 2), `err`=0. Div 100÷0 → (255, 100), `err`=1 and held until the next `BEGIN`; `END` at cycle 6.
- WIDTH=8. Reset pulsed at cycle 6 of a mul → all outputs 0 next cycle. A following add 1+1 → (2, 0) with normal timing. `BEGIN` held high through a whole op → no second op starts before IDLE.
- WIDTH=16. Mul 300×300 → (0x5F90, 0x0001). Div 65535÷256 → (255, 255). `END` at cycle 21.
